triumph_alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared execute-stage ALU. It accepts operations from two independent requesters over valid/ready handshakes and grants the ALU round-robin, one operation at a time. It drives the ALU operand and op-type inputs, which the execute stage registers on the next edge. It then captures the combinational ALU result and zero flag and returns them to the owning requester over a valid/ready response channel. It sits between the decode-side requesters (main pipeline, address/branch helper) and the execute stage.

---
 rtl/triumph_alu_arbiter_pkg.sv | 25 ++
 rtl/triumph_rr_arb2.sv | 18 +
 rtl/triumph_alu_arbiter.sv | 121 ++++++++++++
 tb/tb_triumph_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triumph_alu_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU arbiter: ALU op codes,
// FSM state encoding and small helpers.
package triumph_alu_arbiter_pkg;

  // ALU op-type codes understood by the execute stage (all-zero = default, result 0)
  localparam logic [6:0] ALU_NONE = 7'd0;
  localparam logic [6:0] ALU_ADD  = 7'd1;
  localparam logic [6:0] ALU_SUB  = 7'd2;
  localparam logic [6:0] ALU_AND  = 7'd3;
  localparam logic [6:0] ALU_OR   = 7'd4;
  localparam logic [6:0] ALU_XOR  = 7'd5;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Requester index encoded by a one-hot two-bit grant
  function automatic logic grant_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/triumph_rr_arb2.sv
// Two-way round-robin arbiter, combinational. The requester that was not
// granted last wins a tie; the last-grant register lives in the parent.
module triumph_rr_arb2 (
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone request always wins; on a tie the other-than-last requester wins
  always_comb begin
    grant    = 2'b00;
    grant[0] = enable & req0_valid & (~req1_valid | last_grant);
    grant[1] = enable & req1_valid & (~req0_valid | ~last_grant);
  end

endmodule

// File: rtl/triumph_alu_arbiter.sv
// Arbitrates two requesters onto the shared execute-stage ALU, one
// operation at a time, and returns the captured result to the owner.
module triumph_alu_arbiter
  import triumph_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_op_type_i,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_op_type_i,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_zero_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_zero_o,
  output logic [OP_W-1:0]   alu_op_type_o,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [DATA_W-1:0] alu_op2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              busy_o
);

  arb_state_e        state_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_zero_reg;

  logic [1:0]        grant;
  logic              arb_en;
  logic              rsp_hs;

  // Grants are only made from IDLE and never while reset is held, so no
  // ready pulse can escape during reset even with requesters asserting valid
  assign arb_en = (state_reg == ST_IDLE) & ~rstn_i;

  triumph_rr_arb2 u_rr_arb2 (
    .req0_valid (req0_valid_i),
    .req1_valid (req1_valid_i),
    .enable     (arb_en),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  // Forward the winner's operation to the ALU; all-zero when nothing is issued
  always_comb begin
    alu_op_type_o = '0;
    alu_op1_o     = '0;
    alu_op2_o     = '0;
    if (grant[0]) begin
      alu_op_type_o = req0_op_type_i;
      alu_op1_o     = req0_op1_i;
      alu_op2_o     = req0_op2_i;
    end else if (grant[1]) begin
      alu_op_type_o = req1_op_type_i;
      alu_op1_o     = req1_op1_i;
      alu_op2_o     = req1_op2_i;
    end
  end

  // Response handshake is taken from the owner's ready only
  assign rsp_hs = owner_reg ? rsp1_ready_i : rsp0_ready_i;

  // Sequencer: grant in IDLE, capture the ALU output in EXEC, hold in RESP
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp_data_reg   <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            owner_reg      <= grant_idx(grant);
            last_grant_reg <= grant_idx(grant);
            state_reg      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_reg <= alu_result_i;
          rsp_zero_reg <= alu_zero_i;
          state_reg    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Response channel belongs to the owner only; payload is zero when not valid
  assign rsp0_valid_o = (state_reg == ST_RESP) & ~owner_reg;
  assign rsp1_valid_o = (state_reg == ST_RESP) & owner_reg;
  assign rsp0_data_o  = {DATA_W{rsp0_valid_o}} & rsp_data_reg;
  assign rsp1_data_o  = {DATA_W{rsp1_valid_o}} & rsp_data_reg;
  assign rsp0_zero_o  = rsp0_valid_o & rsp_zero_reg;
  assign rsp1_zero_o  = rsp1_valid_o & rsp_zero_reg;

  assign busy_o = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_triumph_alu_arbiter.sv
// Directed bench for triumph_alu_arbiter: a transaction-level model checks
// every cycle, directed sequences pin the literal results.
module tb_triumph_alu_arbiter;
  import triumph_alu_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int OW = 7;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          req0_valid_i, req1_valid_i;
  logic          req0_ready_o, req1_ready_o;
  logic [OW-1:0] req0_op_type_i, req1_op_type_i;
  logic [DW-1:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
  logic          rsp0_valid_o, rsp1_valid_o;
  logic          rsp0_ready_i, rsp1_ready_i;
  logic [DW-1:0] rsp0_data_o, rsp1_data_o;
  logic          rsp0_zero_o, rsp1_zero_o;
  logic [OW-1:0] alu_op_type_o;
  logic [DW-1:0] alu_op1_o, alu_op2_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  triumph_alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op_type_i(req0_op_type_i), .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op_type_i(req1_op_type_i), .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_data_o(rsp0_data_o), .rsp0_zero_o(rsp0_zero_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_data_o(rsp1_data_o), .rsp1_zero_o(rsp1_zero_o),
    .alu_op_type_o(alu_op_type_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .busy_o(busy_o)
  );

  // Reference ALU behaviour (unknown op codes give 0)
  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Execute stage: registers the issued operation, result is combinational
  logic [OW-1:0] ex_op;
  logic [DW-1:0] ex_a, ex_b;
  always @(posedge clk_i) begin
    ex_op <= alu_op_type_o;
    ex_a  <= alu_op1_o;
    ex_b  <= alu_op2_o;
  end
  assign alu_result_i = alu_fn(ex_op, ex_a, ex_b);
  assign alu_zero_i   = (alu_result_i == '0);

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: at most one outstanding operation, response
  // visible two cycles after acceptance until the owner takes it
  initial begin
    logic          m_out, m_own, m_last, m_zero;
    logic [DW-1:0] m_res;
    int            m_age;
    logic          eg0, eg1, ev0, ev1;
    logic [OW-1:0] e_op;
    logic [DW-1:0] e_a, e_b;
    m_out = 0; m_own = 0; m_last = 1; m_zero = 0; m_res = '0; m_age = 0;
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        m_out = 0; m_own = 0; m_last = 1; m_age = 0;
        chk("m_rst_busy", busy_o, 0);
        chk("m_rst_ready", {req1_ready_o, req0_ready_o}, 0);
        chk("m_rst_rspv", {rsp1_valid_o, rsp0_valid_o}, 0);
        chk("m_rst_aluop", alu_op_type_o, 0);
      end else begin
        eg0 = !m_out && req0_valid_i && (!req1_valid_i || m_last);
        eg1 = !m_out && req1_valid_i && (!req0_valid_i || !m_last);
        ev0 = m_out && (m_age >= 2) && !m_own;
        ev1 = m_out && (m_age >= 2) && m_own;
        e_op = eg0 ? req0_op_type_i : (eg1 ? req1_op_type_i : '0);
        e_a  = eg0 ? req0_op1_i : (eg1 ? req1_op1_i : '0);
        e_b  = eg0 ? req0_op2_i : (eg1 ? req1_op2_i : '0);
        chk("m_ready0", req0_ready_o, eg0);
        chk("m_ready1", req1_ready_o, eg1);
        chk("m_aluop", alu_op_type_o, e_op);
        chk("m_alua", alu_op1_o, e_a);
        chk("m_alub", alu_op2_o, e_b);
        chk("m_busy", busy_o, m_out);
        chk("m_rspv0", rsp0_valid_o, ev0);
        chk("m_rspv1", rsp1_valid_o, ev1);
        chk("m_rspd0", rsp0_data_o, ev0 ? m_res : '0);
        chk("m_rspd1", rsp1_data_o, ev1 ? m_res : '0);
        chk("m_rspz0", rsp0_zero_o, ev0 & m_zero);
        chk("m_rspz1", rsp1_zero_o, ev1 & m_zero);
        if (eg0 || eg1) begin
          m_out = 1; m_own = eg1; m_last = eg1; m_age = 1;
          m_res = alu_fn(e_op, e_a, e_b); m_zero = (m_res == '0);
        end else if (m_out) begin
          if (m_age >= 2 && (m_own ? rsp1_ready_i : rsp0_ready_i)) m_out = 0;
          else if (m_age < 2) m_age++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (n == 0) begin
      req0_valid_i = v; req0_op_type_i = op; req0_op1_i = a; req0_op2_i = b;
    end else begin
      req1_valid_i = v; req1_op_type_i = op; req1_op1_i = a; req1_op2_i = b;
    end
  endtask

  // Called at the negedge of the accept cycle: drop valid, expect the result at T+2
  task automatic finish_after_accept(input int n, input logic [DW-1:0] d, input logic z);
    tick();
    if (n == 0) req0_valid_i = 0; else req1_valid_i = 0;
    @(negedge clk_i);
    chk("t1_no_rsp", n == 0 ? rsp0_valid_o : rsp1_valid_o, 0);
    @(negedge clk_i);
    chk("t2_rsp_valid", n == 0 ? rsp0_valid_o : rsp1_valid_o, 1);
    chk("t2_rsp_data", n == 0 ? rsp0_data_o : rsp1_data_o, d);
    chk("t2_rsp_zero", n == 0 ? rsp0_zero_o : rsp1_zero_o, z);
    $display("txn req%0d: data=0x%0h zero=%0b", n, n == 0 ? rsp0_data_o : rsp1_data_o,
             n == 0 ? rsp0_zero_o : rsp1_zero_o);
  endtask

  task automatic run_op(input int n, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] d, input logic z);
    logic got;
    got = 0;
    set_req(n, 1, op, a, b);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if ((n == 0) ? req0_ready_o : req1_ready_o) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("grant_seen", got, 1);
    if (got) finish_after_accept(n, d, z);
    else if (n == 0) req0_valid_i = 0; else req1_valid_i = 0;
  endtask

  initial begin
    rstn_i = 1;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    rsp0_ready_i = 1; rsp1_ready_i = 1;
    #3;
    chk("reset_busy", busy_o, 0);
    chk("reset_ready", {req1_ready_o, req0_ready_o}, 0);
    chk("reset_rspv", {rsp1_valid_o, rsp0_valid_o}, 0);
    chk("reset_alu", alu_op1_o | alu_op2_o, 0);
    repeat (2) tick();
    rstn_i = 0;

    // Single op, then zero flag on requester 1
    tick(); run_op(0, ALU_ADD, 5, 3, 8, 0);
    tick(); run_op(1, ALU_SUB, 7, 7, 0, 1);

    // Tie: requester 0 first, requester 1 right after the handshake
    tick();
    set_req(0, 1, ALU_XOR, 32'hF0, 32'h0F);
    set_req(1, 1, ALU_OR, 1, 2);
    @(negedge clk_i);
    chk("tie_r0_ready", req0_ready_o, 1);
    chk("tie_r1_wait", req1_ready_o, 0);
    finish_after_accept(0, 32'hFF, 0);
    chk("tie_r1_in_resp", req1_ready_o, 0);
    tick(); @(negedge clk_i);
    chk("tie_r1_ready", req1_ready_o, 1);
    finish_after_accept(1, 3, 0);

    // Second tie: requester 0 wins again since 1 went last
    tick();
    set_req(0, 1, ALU_ADD, 1, 1);
    set_req(1, 1, ALU_ADD, 2, 2);
    @(negedge clk_i);
    chk("tie2_r0_ready", req0_ready_o, 1);
    finish_after_accept(0, 2, 0);
    tick(); @(negedge clk_i);
    chk("tie2_r1_ready", req1_ready_o, 1);
    finish_after_accept(1, 4, 0);

    // Backpressure on requester 0 while requester 1 waits
    tick();
    rsp0_ready_i = 0;
    set_req(0, 1, ALU_ADD, 10, 20);
    @(negedge clk_i);
    chk("bp_grant", req0_ready_o, 1);
    tick();
    req0_valid_i = 0;
    set_req(1, 1, ALU_AND, 32'hFF, 32'h0F);
    @(negedge clk_i); @(negedge clk_i);
    chk("bp_rsp_valid", rsp0_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk_i);
      chk("bp_hold_valid", rsp0_valid_o, 1);
      chk("bp_hold_data", rsp0_data_o, 30);
      chk("bp_hold_zero", rsp0_zero_o, 0);
      chk("bp_r1_blocked", req1_ready_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    tick(); rsp0_ready_i = 1;
    @(negedge clk_i);
    chk("bp_hs_no_grant", req1_ready_o, 0);
    tick(); @(negedge clk_i);
    chk("bp_r1_ready", req1_ready_o, 1);
    finish_after_accept(1, 32'h0F, 0);

    // Reset asserted during EXEC
    tick();
    set_req(0, 1, ALU_ADD, 1, 2);
    @(negedge clk_i);
    chk("rmid_grant", req0_ready_o, 1);
    tick(); req0_valid_i = 0;
    #2; rstn_i = 1; req1_valid_i = 1;
    #1;
    chk("rmid_busy", busy_o, 0);
    chk("rmid_rspv", {rsp1_valid_o, rsp0_valid_o}, 0);
    chk("rmid_ready", {req1_ready_o, req0_ready_o}, 0);
    chk("rmid_alu", alu_op_type_o, 0);
    req1_valid_i = 0;
    @(negedge clk_i);
    tick(); rstn_i = 0;
    tick(); run_op(0, ALU_ADD, 5, 3, 8, 0);

    // Idle drive
    for (int i = 0; i < 10; i++) begin
      tick(); @(negedge clk_i);
      chk("idle_alu", {alu_op_type_o, alu_op1_o | alu_op2_o} == 0, 1);
      chk("idle_busy", busy_o, 0);
      chk("idle_rspv", {rsp1_valid_o, rsp0_valid_o}, 0);
    end

    // Both valid in the cycle reset deasserts
    tick(); rstn_i = 1;
    tick(); rstn_i = 0;
    set_req(0, 1, ALU_ADD, 3, 4);
    set_req(1, 1, ALU_ADD, 5, 6);
    @(negedge clk_i);
    chk("rel_r0_ready", req0_ready_o, 1);
    chk("rel_r1_wait", req1_ready_o, 0);
    finish_after_accept(0, 7, 0);
    tick(); @(negedge clk_i);
    chk("rel_r1_ready", req1_ready_o, 1);
    finish_after_accept(1, 11, 0);

    // Unknown op code passes through and yields result 0, zero=1
    tick(); run_op(0, 7'h55, 9, 9, 0, 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
